vend_dispense_arbiter: RTL
==========================

# vend_dispense_arbiter

Round-robin arbiter and sequencer that shares one physical dispense mechanism (drink motor plus change ejector) among several vending front-ends. Each front-end is a coin/drink selection FSM that has already settled a transaction. The block grants one requester at a time and latches its drink code and change flag. It then drives the motor through a done/timeout handshake, pulses the change ejector, and returns a one-cycle acknowledge to the served requester.

## Interface
- NREQ, 4: number of front-end requesters, 2..8.
- TIMEOUT_CYC, 255: maximum DISP cycles to wait for motor_done before faulting, 1..65535.
- clk  in  1  clock; all inputs synchronous to it.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester dispense request; level, held until matching ack.
- req_drink  in  2*NREQ  drink code per requester, slice i = [2i+1:2i]; 0 = none, 1 = 5-unit, 2 = 10-unit, 3 = both.
- req_chang  in  NREQ  per-requester change-due flag.
- motor_done  in  1  dispense mechanism completion level; honoured only in DISP.
- ack  out  NREQ  one-hot, one-cycle pulse to the served requester.
- motor_on  out  1  motor enable.
- motor_sel  out  2  drink code being dispensed; valid while motor_on=1.
- chang_out  out  1  change-ejector pulse, one cycle.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  sticky motor timeout flag; cleared only by reset.

## Operation
- States: IDLE, GRANT, DISP, CHANGE, ACK; state register is one-hot.
- IDLE: if any req bit is set, select a winner round-robin and go to GRANT. Otherwise stay in IDLE.
- Round-robin: search starts at index ptr, wrapping at NREQ-1 → 0. ptr resets to 0 and is set to winner+1 (mod NREQ) at entry to ACK.
- GRANT, one cycle: latch the winner index, req_drink slice and req_chang into internal registers. Go to DISP if the latched drink ≠ 0; otherwise go to CHANGE.
- DISP: motor_on=1, motor_sel=latched drink. A timeout counter loads 0 on entry and increments each cycle.
  - motor_done=1 → go to CHANGE.
  - Counter reaches TIMEOUT_CYC-1 without done → set fault, go to ACK, skip change.
- CHANGE, one cycle: chang_out = latched change flag. Go to ACK.
- ACK, one cycle: ack[winner]=1. Go to IDLE.
- Requester inputs are sampled only in IDLE (arbitration) and GRANT (latch). Later changes, including req dropping mid-service, do not abort service; ack still pulses.
- Ties cannot occur; round-robin order resolves simultaneous requests.
- fault does not block operation; later requests are served normally.
- [VEND_ARB_STATS_EN] served_cnt (out, 16 bits): counts ACK cycles whose service did not time out. It wraps from 0xFFFF to 0.

## Timing
- Reset values: ack=0, motor_on=0, motor_sel=0, chang_out=0, busy=0, fault=0, ptr=0, state=IDLE, served_cnt=0. Reset acts immediately mid-operation and drops motor_on asynchronously.
- All outputs are registered or decoded from the one-hot state plus latched registers; no combinational input→output paths.
- req first high at edge k (IDLE) → GRANT after edge k, busy=1 → motor_on=1 after edge k+1.
- motor_done sampled high at edge d in DISP → motor_on=0 and CHANGE after edge d, ACK after edge d+1, IDLE after edge d+2.
- Zero-drink request: GRANT → CHANGE → ACK, i.e. ack 3 cycles after the IDLE-sampling edge.
- Timeout: motor_on is high for exactly TIMEOUT_CYC cycles. fault and ack rise on the same edge.
- Back-to-back: one IDLE cycle between consecutive services minimum.

## Configuration
- VEND_ARB_STATS_EN defined: the served_cnt port and counter exist as described.
- VEND_ARB_STATS_EN undefined: no port and no counter logic; all other behaviour is identical.

## Test plan
- Single service: req[1]=1, req_drink slice 1=2, req_chang[1]=1; motor_done rises 5 cycles into DISP. Expect motor_sel=2 with motor_on high 5 cycles, then chang_out pulse, then ack=0b0010 one cycle later, then busy=0.
- Fairness: req=4'b1111 held, each dispense acked. Expect service order 0,1,2,3,0; ptr wraps 3→0.
- Timeout: TIMEOUT_CYC=10, motor_done held 0. Expect motor_on high exactly 10 cycles, fault=1 with ack pulse, no chang_out. A following request is served with fault still 1.
- Zero drink: req[2]=1, drink=0, chang=1. Expect motor_on never asserts, chang_out pulse, ack[2] 3 cycles after sampling.
- Reset mid-DISP: assert rst_n=0 while motor_on=1. Expect all outputs 0 immediately and the first post-reset grant going to the lowest pending index.
- Stats (VEND_ARB_STATS_EN): 3 normal services plus 1 timeout. Expect served_cnt=3; preload near wrap with 0xFFFF + 1 service → 0.

Source files
------------

// File: rtl/vend_dispense_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vend_dispense_arbiter
// Description : Round-robin arbiter/sequencer sharing one dispense mechanism
//               (drink motor + change ejector) among NREQ vending front-ends.
//               Grants one requester, latches its drink code and change flag,
//               runs the motor through a done/timeout handshake, pulses the
//               change ejector and acknowledges the served requester.
// Options     : define VEND_ARB_STATS_EN to add the served_cnt output, a
//               16-bit wrapping count of services that did not time out.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_dispense_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_drink,
  input  logic [NREQ-1:0]      req_chang,
  input  logic                 motor_done,
  output logic [NREQ-1:0]      ack,
  output logic                 motor_on,
  output logic [1:0]           motor_sel,
  output logic                 chang_out,
  output logic                 busy,
  output logic                 fault
`ifdef VEND_ARB_STATS_EN
  ,
  output logic [15:0]          served_cnt
`endif
);

  localparam int          IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  // One-hot encoded sequencer states
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_GRANT  = 5'b00010,
    S_DISP   = 5'b00100,
    S_CHANGE = 5'b01000,
    S_ACK    = 5'b10000
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDXW-1:0]   ptr;        // round-robin search start
  logic [IDXW-1:0]   win;        // index of requester being served
  logic [IDXW-1:0]   win_nxt;    // arbitration result in IDLE
  logic [IDXW-1:0]   ptr_nxt;    // winner+1 wrapped at NREQ
  logic [IDXW-1:0]   cand;
  logic [IDXW:0]     sum;
  logic              found;
  logic [1:0]        drink;      // latched drink code
  logic              chang;      // latched change-due flag
  logic              timed_out;  // current service ended by timeout
  logic [15:0]       tmr;        // cycles spent in DISP
  logic [1:0]        win_drink;  // drink slice of the granted requester

  assign win_drink = req_drink[{win, 1'b0} +: 2];
  assign ptr_nxt   = (win == IDXW'(NREQ - 1)) ? '0 : win + 1'b1;

  // Round-robin search: first pending request at or after ptr, wrapping
  always_comb begin
    win_nxt = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDXW+1)'(i);
      if (sum >= (IDXW+1)'(NREQ)) begin
        sum = sum - (IDXW+1)'(NREQ);
      end
      cand = sum[IDXW-1:0];
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_nxt = cand;
      end
    end
  end

  // State register; reset drops motor_on at once since it decodes from state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and outputs decoded from state plus latched registers
  always_comb begin
    state_nxt = state;
    ack       = '0;
    motor_on  = 1'b0;
    motor_sel = 2'b00;
    chang_out = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (|req) begin
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        // The drink being latched this cycle decides whether the motor runs
        state_nxt = (win_drink != 2'b00) ? S_DISP : S_CHANGE;
      end
      S_DISP: begin
        motor_on  = 1'b1;
        motor_sel = drink;
        // A done arriving on the last allowed cycle still counts as success
        if (motor_done) begin
          state_nxt = S_CHANGE;
        end else if (tmr == TO_LAST) begin
          state_nxt = S_ACK;
        end
      end
      S_CHANGE: begin
        chang_out = chang;
        state_nxt = S_ACK;
      end
      S_ACK: begin
        ack       = {{(NREQ-1){1'b0}}, 1'b1} << win;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Service datapath: winner, latched request data, timer, pointer, fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win       <= '0;
      ptr       <= '0;
      drink     <= 2'b00;
      chang     <= 1'b0;
      tmr       <= '0;
      timed_out <= 1'b0;
      fault     <= 1'b0;
    end else begin
      if (state == S_IDLE && (|req)) begin
        win <= win_nxt;
      end
      if (state == S_GRANT) begin
        drink     <= win_drink;
        chang     <= req_chang[win];
        tmr       <= '0;
        timed_out <= 1'b0;
      end
      if (state == S_DISP) begin
        tmr <= tmr + 16'd1;
        if (!motor_done && tmr == TO_LAST) begin
          fault     <= 1'b1;
          timed_out <= 1'b1;
        end
      end
      // ACK is only ever entered from DISP or CHANGE, so this is ACK entry
      if (state_nxt == S_ACK && state != S_ACK) begin
        ptr <= ptr_nxt;
      end
    end
  end

`ifdef VEND_ARB_STATS_EN
  logic [15:0] served_q;

  // Count acknowledged services that completed without a motor timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_q <= '0;
    end else if (state == S_ACK && !timed_out) begin
      served_q <= served_q + 16'd1;
    end
  end

  assign served_cnt = served_q;
`endif

endmodule
`default_nettype wire
